// File: rtl/arb_pkg.sv
// Shared types for the 4-requester round-robin arbiter.
// Latency: none (types and a pure decode helper only).
// Backpressure: not applicable.
package arb_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] grant_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input grant_t g);
    logic [N_REQ-1:0] r;
    r    = '0;
    r[g] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mux4_64.sv
// 4:1 payload select feeding the arbiter output register.
// Latency: purely combinational.
// Backpressure: none.
module mux4_64 #(
  parameter int W = 64
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Round-robin picker: first set request bit at or after ptr, wrapping mod 4.
// Latency: purely combinational.
// Backpressure: none; found=0 when no bit is set.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  grant_t           ptr,
  output logic             found,
  output grant_t           winner
);

  grant_t idx;

  // Walk from the farthest offset back to ptr so the nearest set bit wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + grant_t'(i);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4to1_64.sv
// Round-robin 4:1 arbiter into one registered 64-bit output; ARB_BURST_LOCK_EN adds burst locking.
// Latency: 1 cycle from request handshake to o_valid; full throughput with i_ready held high.
// Backpressure: o_req_ready stays low while the output register is full and i_ready is low.
module rr_arbiter_4to1_64
  import arb_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_REQ-1:0]  i_req_valid,
  input  logic [DATA_W-1:0] i_req_data_0,
  input  logic [DATA_W-1:0] i_req_data_1,
  input  logic [DATA_W-1:0] i_req_data_2,
  input  logic [DATA_W-1:0] i_req_data_3,
`ifdef ARB_BURST_LOCK_EN
  input  logic [N_REQ-1:0]  i_req_last,
`endif
  output logic [N_REQ-1:0]  o_req_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output grant_t            o_grant,
  input  logic              i_ready
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  grant_t            ptr;
  grant_t            win;
  logic              found;
  logic              can_load;
  logic              take;
  logic [N_REQ-1:0]  eligible;
  logic [DATA_W-1:0] mux_dat;

`ifdef ARB_BURST_LOCK_EN
  logic   locked;
  grant_t lock_id;

  // While a burst is open only its owner may compete.
  always_comb begin
    eligible = i_req_valid;
    if (locked) eligible = i_req_valid & onehot(lock_id);
  end
`else
  assign eligible = i_req_valid;
`endif

  rr_pick4 u_pick (
    .req    (eligible),
    .ptr    (ptr),
    .found  (found),
    .winner (win)
  );

  mux4_64 #(
    .W (DATA_W)
  ) u_mux (
    .d0  (i_req_data_0),
    .d1  (i_req_data_1),
    .d2  (i_req_data_2),
    .d3  (i_req_data_3),
    .sel (win),
    .y   (mux_dat)
  );

  assign can_load    = (state == EMPTY) || i_ready;
  assign take        = can_load && found && !i_reset;
  assign o_req_ready = take ? onehot(win) : '0;
  assign o_valid     = (state == FULL);

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= EMPTY;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (can_load) state_nxt = found ? FULL : EMPTY;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data  <= '0;
      o_grant <= '0;
    end else if (take) begin
      o_data  <= mux_dat;
      o_grant <= win;
    end
  end

`ifdef ARB_BURST_LOCK_EN
  // Pointer moves only when a burst closes, so the owner keeps its turn.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr     <= '0;
      locked  <= 1'b0;
      lock_id <= '0;
    end else if (take) begin
      if (i_req_last[win]) begin
        ptr    <= win + 2'd1;
        locked <= 1'b0;
      end else begin
        locked  <= 1'b1;
        lock_id <= win;
      end
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (i_reset)   ptr <= '0;
    else if (take) ptr <= win + 2'd1;
  end
`endif

endmodule

// File: doc/rr_arbiter_4to1_64.md
Name: rr_arbiter_4to1_64

Overview:
- Round-robin arbiter sharing one 64-bit destination port among four requesters.
- Each requester uses a valid/ready handshake.
- The winner's data is captured into a single output register and presented downstream with valid/ready.
- Drives the 2-bit select of the 4:1 64-bit datapath mux and exports the registered grant index for the consumer.

Parameters:
- DATA_W, 64, width of each request payload and of the output data.
- N_REQ, 4, number of requesters; fixed at 4 because the grant index is 2 bits.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_req_valid  in  4  per-requester valid; bit k belongs to requester k
- i_req_data_0..3  in  DATA_W each  requester payloads
- o_req_ready  out  4  one-hot or zero; high for exactly the requester accepted this cycle
- o_valid  out  1  output register holds a valid payload
- o_data  out  DATA_W  registered payload
- o_grant  out  2  index of the requester that supplied o_data
- i_ready  in  1  downstream accepts o_data when o_valid & i_ready

Behaviour:
- One clock domain, i_clk. Reset is synchronous and active-high on i_reset.
- Reset values: o_valid=0, o_data=0, o_grant=0, round-robin pointer=0 (requester 0 has highest priority first).
- Reset wins over every other event in that cycle. Reset mid-transfer drops the held payload; no requester sees ready in that cycle.
- States:
  - EMPTY: o_valid=0.
  - FULL: o_valid=1.
- can_load = EMPTY or (FULL and i_ready).
- When can_load and any i_req_valid bit is set:
  - Pick the winner w: the first set bit searching from pointer, pointer+1, ... mod 4.
  - o_req_ready[w]=1 in the same cycle; this is combinational from i_req_valid, state and i_ready.
  - Next edge: o_data <= i_req_data_w, o_grant <= w, o_valid <= 1, pointer <= w+1 mod 4 (wraps 3 -> 0).
- When can_load and no request: o_valid <= 0 (EMPTY). o_data and o_grant hold their values.
- When FULL and !i_ready: all o_req_ready=0. o_valid, o_data, o_grant and pointer hold.
- Latency: 1 cycle from handshake to o_valid.
- Throughput: 1 transfer per cycle when i_ready is held high (back-to-back, no bubble).
- Pointer advances only on a granted handshake, never on idle cycles.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0...; each requester waits at most 3 grants.
- The payload mux select equals w; the mux output is combinational and feeds the o_data register input.
- i_req_data_k is sampled only on its own handshake edge; requesters must hold data stable while valid and not ready.
- o_req_ready bits are never multi-hot.

Optional Feature:
- Macro: ARB_BURST_LOCK_EN.
- With it:
  - Extra input i_req_last (4 bits).
  - Once requester w wins a beat with i_req_last[w]=0, the arbiter locks to w.
  - While locked, only w is eligible and others are ignored even if valid.
  - The lock is released after the handshake of a beat with i_req_last[w]=1.
  - The pointer updates to w+1 only on release.
  - Reset clears the lock.
- Without it: no i_req_last port; every beat is arbitrated independently (single-beat behaviour above).

Decomposition:
- Package arb_pkg holds:
  - localparam N_REQ=4
  - typedef logic [1:0] grant_t
  - typedef enum {EMPTY, FULL} arb_state_t
- Sub-module rr_pick4: purely combinational. Inputs: 4-bit request and grant_t pointer. Outputs: found flag and grant_t winner.
- The payload select uses the existing 4:1 64-bit mux instance, driven by the winner index.

Test Plan:
- Reset then idle: i_req_valid=0000 for 5 cycles -> o_valid=0, o_req_ready=0000, o_grant=0.
- Single request: req 2 valid, data 0xDEAD_BEEF_0000_0002, i_ready=1 -> o_req_ready=0100 same cycle; next cycle o_valid=1, o_data=0xDEAD_BEEF_0000_0002, o_grant=2.
- All four valid continuously, i_ready=1, payload k = 0x1000+k -> o_grant sequence 0,1,2,3,0,1 with no gaps; o_data matches.
- Backpressure: FULL with req 1 valid, i_ready=0 for 3 cycles -> o_req_ready=0000, o_data stable; i_ready=1 -> req 1 accepted that cycle.
- Wrap: pointer at 3, requests 0001 and 1000 simultaneously -> 3 wins; next cycle 0 wins.
- Reset mid-transfer: o_valid=1, assert i_reset one cycle with i_req_valid=1111 -> o_req_ready=0000 that cycle; o_valid=0 next; first subsequent grant goes to requester 0.
- (ARB_BURST_LOCK_EN) req 1 sends 3 beats with last on beat 3 while req 0 is valid -> grants 1,1,1, then 2/3/0 per pointer; req 0 is not granted before beat 3 completes.
